// File: rtl/mul16_seq_if.sv
// Request/result bundle of the sequential 16x16 multiplier.
// The master drives operands and start; the slave returns busy, done and the product.
interface mul16_seq_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned shift-add multiplier (one partial product per clock).
// The partial-sum adder is a 16-bit ripple of four 4-bit carry-lookahead blocks.

module cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g    = i_a & i_b;
  assign w_p    = i_a ^ i_b;
  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);
  assign o_s    = w_p ^ w_c[3:0];
  assign o_c    = w_c[4];
endmodule

module adder16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  logic [4:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar g = 0; g < 4; g++) begin : g_blk
    cla4 u_cla4 (
      .i_a (i_a[4*g +: 4]),
      .i_b (i_b[4*g +: 4]),
      .i_c (w_carry[g]),
      .o_s (o_sum[4*g +: 4]),
      .o_c (w_carry[g+1])
    );
  end

  assign o_cout = w_carry[4];
endmodule

module mul16_seq (
  input  logic            clk,
  input  logic            clr_n,
  mul16_seq_if.slave      bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_m;
  logic [15:0] r_p_hi;
  logic [15:0] r_p_lo;
  logic [3:0]  r_cnt;
  logic [31:0] r_product;

  logic        w_accept;
  logic        w_last;
  logic [15:0] w_addend;
  logic [15:0] w_sum;
  logic        w_cout;
  logic [31:0] w_shift;

  assign w_accept = (r_state != S_RUN) && bus.start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == 4'd15);
  assign w_addend = r_p_lo[0] ? r_m : '0;

  adder16 u_adder16 (
    .i_a    (r_p_hi),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Carry-out becomes the new MSB, so the running product never overflows.
  assign w_shift = {w_cout, w_sum, r_p_lo[15:1]};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = bus.start ? S_RUN : S_IDLE;
      S_RUN:   w_next = (r_cnt == 4'd15) ? S_DONE : S_RUN;
      S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_m       <= '0;
      r_p_hi    <= '0;
      r_p_lo    <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_m    <= bus.a;
      r_p_hi <= '0;
      r_p_lo <= bus.b;
      r_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      {r_p_hi, r_p_lo} <= w_shift;
      r_cnt            <= r_cnt + 4'd1;
      if (w_last) r_product <= w_shift;
    end
  end

  assign bus.busy    = (r_state == S_RUN);
  assign bus.done    = (r_state == S_DONE);
  assign bus.product = r_product;
endmodule

// File: tb/tb_mul16_seq.sv
// Directed-vector bench for mul16_seq: product values, busy/done timing,
// start-during-run, back-to-back starts and asynchronous clear mid-operation.
module tb_mul16_seq;
  logic clk;
  logic clr_n;
  int   n_cmp;
  int   n_err;
  logic [31:0] last_prod;

  mul16_seq_if bus ();

  mul16_seq dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Samples are taken 1 time unit after edges E0..E17 (index k = edge number).
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb2,
                        input logic [31:0] exp, input string nm);
    int busy_bad = 0;
    int done_cnt = 0;
    int done_idx = -1;
    logic [31:0] held = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb2;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
      end
      if (bus.busy !== (k < 16)) busy_bad++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_idx = k;
      end
      if (k == 15) held = bus.product;
      if (k == 16) check({nm, " product"}, bus.product, exp);
    end
    check({nm, " busy_window"}, 32'(busy_bad), 32'd0);
    check({nm, " done_pulses"}, 32'(done_cnt), 32'd1);
    check({nm, " done_edge"}, 32'(done_idx), 32'd16);
    check({nm, " product_hold_before"}, held, last_prod);
    check({nm, " product_hold_after"}, bus.product, exp);
    last_prod = exp;
  endtask

  initial begin
    int done_seen;
    int busy_seen;
    n_cmp     = 0;
    n_err     = 0;
    last_prod = '0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    vecs[0]  = '{16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2]  = '{16'h1234, 16'h0000, 32'h0000_0000};
    vecs[3]  = '{16'h0000, 16'h0000, 32'h0000_0000};
    vecs[4]  = '{16'h0001, 16'h0001, 32'h0000_0001};
    vecs[5]  = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
    vecs[6]  = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
    vecs[7]  = '{16'h8000, 16'h8000, 32'h4000_0000};
    vecs[8]  = '{16'h00FF, 16'h0100, 32'h0000_FF00};
    vecs[9]  = '{16'h1234, 16'h0010, 32'h0001_2340};
    vecs[10] = '{16'hFFFF, 16'h0002, 32'h0001_FFFE};
    vecs[11] = '{16'h0100, 16'h0100, 32'h0001_0000};
    vecs[12] = '{16'hABCD, 16'h0001, 32'h0000_ABCD};
    vecs[13] = '{16'h0000, 16'h1234, 32'h0000_0000};

    // Asynchronous clear before any clock edge.
    clr_n = 1'b0;
    #3;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset product", bus.product, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    // start held through the run, operands changed mid-run, second op from DONE.
    done_seen = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h0007;
    bus.b     = 16'h0009;
    for (int k = 0; k < 17; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        bus.a = 16'hFFFF;
        bus.b = 16'hFFFF;
      end
      if (k < 16 && bus.done === 1'b1) done_seen++;
      if (k == 16) begin
        check("held_start done", 32'(bus.done), 32'd1);
        check("held_start product", bus.product, 32'h0000_003F);
        bus.a = 16'h0002;
        bus.b = 16'h0003;
      end
    end
    check("held_start early_done", 32'(done_seen), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b busy", 32'(bus.busy), 32'd1);
    check("b2b done_single", 32'(bus.done), 32'd0);
    done_seen = 0;
    for (int k = 1; k < 17; k++) begin
      @(posedge clk); #1;
      if (k < 16 && bus.done === 1'b1) done_seen++;
      if (k == 15) check("b2b hold", bus.product, 32'h0000_003F);
      if (k == 16) begin
        check("b2b done", 32'(bus.done), 32'd1);
        check("b2b product", bus.product, 32'h0000_0006);
      end
    end
    check("b2b early_done", 32'(done_seen), 32'd0);
    last_prod = 32'h0000_0006;
    @(posedge clk); #1;

    // Clear asserted after iteration 8 of 0x00FF * 0x0100.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h00FF;
    bus.b     = 16'h0100;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      if (k == 0) bus.start = 1'b0;
    end
    #2;
    clr_n = 1'b0;
    #1;
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    check("midrst product", bus.product, 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_seen++;
      if (bus.busy === 1'b1) busy_seen++;
    end
    check("midrst no_done", 32'(done_seen), 32'd0);
    check("midrst no_busy", 32'(busy_seen), 32'd0);
    last_prod = '0;
    run_op(16'h00FF, 16'h0100, 32'h0000_FF00, "after_rst");

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      run_op(ra, rb, {16'h0, ra} * {16'h0, rb}, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
